bgr2gray_binarization: RTL and testbench



---
 rtl/bgr2gray_binarization_pkg.sv | 49 ++++
 rtl/bgr2gray_stage.sv | 148 ++++++++++++++
 rtl/binarize_stage.sv | 76 +++++++
 rtl/bmp_dp_ram.sv | 38 +++
 rtl/bgr2gray_binarization.sv | 66 ++++++
 tb/tb_bgr2gray_binarization.sv | 233 +++++++++++++++++++++++
 6 files changed

// File: rtl/bgr2gray_binarization_pkg.sv
// Shared constants, state encodings and the gray-weighting helper for the
// BMP grayscale + binarization pipeline.
package bgr2gray_binarization_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int HDR_SIZE   = 54;
    localparam int WIDTH      = 4;
    localparam int HEIGHT     = 4;
    localparam int NUM_PIX    = WIDTH * HEIGHT;
    localparam int TOTAL_SIZE = HDR_SIZE + 3 * NUM_PIX;
    localparam int RAM_DEPTH  = TOTAL_SIZE + 2;
    localparam int ADDR_WIDTH = $clog2(TOTAL_SIZE + 2);
    localparam int THRESHOLD  = 128;

    typedef logic [BYTE_WIDTH-1:0] byte_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam byte_t GRAY_COEF_R = 8'd77;
    localparam byte_t GRAY_COEF_G = 8'd150;
    localparam byte_t GRAY_COEF_B = 8'd29;

    typedef enum logic [2:0] {
        GS_IDLE,
        GS_HDR,
        GS_PIX_RD,
        GS_PIX_WR,
        GS_FIN
    } gray_state_t;

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_RD,
        BS_WR0,
        BS_WR1,
        BS_WR2,
        BS_FIN
    } bin_state_t;

    // Coefficients sum to 256, so the 16-bit sum tops out at 65280 and the
    // upper byte is the weighted luminance.
    function automatic byte_t gray_of(input byte_t b, input byte_t g, input byte_t r);
        logic [15:0] acc;
        acc = {8'd0, GRAY_COEF_R} * {8'd0, r}
            + {8'd0, GRAY_COEF_G} * {8'd0, g}
            + {8'd0, GRAY_COEF_B} * {8'd0, b};
        return byte_t'(acc >> 8);
    endfunction

endpackage

// File: rtl/bgr2gray_stage.sv
// Grayscale stage: streams the BMP from ROM, copies the header verbatim and
// replaces each BGR triple with three copies of its gray value (RAM port 1).
module bgr2gray_stage
    import bgr2gray_binarization_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    output logic  rom_ren,
    output addr_t rom_addr,
    input  byte_t rom_out,
    output logic  ram_we,
    output addr_t ram_addr,
    output byte_t ram_wdata,
    output logic  gray_done
);

    gray_state_t state_reg;
    addr_t       cnt_reg;
    logic [1:0]  phase_reg;
    addr_t       pix_base_reg;
    byte_t       b_reg;
    byte_t       g_reg;
    byte_t       gray_reg;
    logic        rom_ren_reg;
    addr_t       rom_addr_reg;
    logic        gray_done_reg;
    byte_t       gray_now;

    // R arrives on the first write cycle, so gray is formed combinationally
    // from the two latched bytes and the live ROM output.
    assign gray_now = gray_of(b_reg, g_reg, rom_out);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_reg)
            GS_HDR: begin
                // cnt_reg == n carries ROM byte n-1, which belongs at index n.
                if (cnt_reg != '0) begin
                    ram_we    = 1'b1;
                    ram_addr  = cnt_reg;
                    ram_wdata = rom_out;
                end
            end
            GS_PIX_WR: begin
                ram_we    = 1'b1;
                ram_addr  = pix_base_reg + addr_t'(phase_reg) + addr_t'(1);
                ram_wdata = (phase_reg == 2'd0) ? gray_now : gray_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= GS_IDLE;
            cnt_reg       <= '0;
            phase_reg     <= '0;
            pix_base_reg  <= '0;
            b_reg         <= '0;
            g_reg         <= '0;
            gray_reg      <= '0;
            rom_ren_reg   <= 1'b0;
            rom_addr_reg  <= '0;
            gray_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                GS_IDLE: begin
                    if (in_valid) begin
                        state_reg    <= GS_HDR;
                        cnt_reg      <= '0;
                        rom_ren_reg  <= 1'b1;
                        rom_addr_reg <= '0;
                    end
                end
                GS_HDR: begin
                    cnt_reg <= cnt_reg + addr_t'(1);
                    if (cnt_reg == addr_t'(HDR_SIZE)) begin
                        state_reg    <= GS_PIX_RD;
                        phase_reg    <= '0;
                        pix_base_reg <= addr_t'(HDR_SIZE);
                        rom_ren_reg  <= 1'b1;
                        rom_addr_reg <= addr_t'(HDR_SIZE);
                    end else if (cnt_reg == addr_t'(HDR_SIZE - 1)) begin
                        rom_ren_reg <= 1'b0;
                    end else begin
                        rom_addr_reg <= cnt_reg + addr_t'(1);
                    end
                end
                GS_PIX_RD: begin
                    case (phase_reg)
                        2'd0: begin
                            rom_addr_reg <= pix_base_reg + addr_t'(1);
                            phase_reg    <= 2'd1;
                        end
                        2'd1: begin
                            b_reg        <= rom_out;
                            rom_addr_reg <= pix_base_reg + addr_t'(2);
                            phase_reg    <= 2'd2;
                        end
                        default: begin
                            g_reg       <= rom_out;
                            rom_ren_reg <= 1'b0;
                            phase_reg   <= 2'd0;
                            state_reg   <= GS_PIX_WR;
                        end
                    endcase
                end
                GS_PIX_WR: begin
                    case (phase_reg)
                        2'd0: begin
                            gray_reg  <= gray_now;
                            phase_reg <= 2'd1;
                        end
                        2'd1: begin
                            phase_reg <= 2'd2;
                        end
                        default: begin
                            phase_reg <= 2'd0;
                            if (pix_base_reg == addr_t'(TOTAL_SIZE - 3)) begin
                                state_reg     <= GS_FIN;
                                gray_done_reg <= 1'b1;
                            end else begin
                                state_reg    <= GS_PIX_RD;
                                pix_base_reg <= pix_base_reg + addr_t'(3);
                                rom_addr_reg <= pix_base_reg + addr_t'(3);
                                rom_ren_reg  <= 1'b1;
                            end
                        end
                    endcase
                end
                GS_FIN: begin
                    gray_done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= GS_IDLE;
                end
            endcase
        end
    end

    assign rom_ren   = rom_ren_reg;
    assign rom_addr  = rom_addr_reg;
    assign gray_done = gray_done_reg;

endmodule

// File: rtl/binarize_stage.sv
// Threshold stage: rewrites every gray pixel in RAM (port 2) as 00 or FF,
// leaving the header untouched.
module binarize_stage
    import bgr2gray_binarization_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  gray_done,
    output logic  ram_we,
    output logic  ram_re,
    output addr_t ram_addr,
    output byte_t ram_wdata,
    input  byte_t ram_rdata,
    output logic  done
);

    bin_state_t state_reg;
    addr_t      base_reg;
    logic       done_reg;

    // The read data register only reloads in RD, so it stays valid for all
    // three write cycles of the pixel.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = base_reg;
        ram_wdata = (ram_rdata >= byte_t'(THRESHOLD)) ? 8'hFF : 8'h00;
        case (state_reg)
            BS_RD:  ram_re = 1'b1;
            BS_WR0: ram_we = 1'b1;
            BS_WR1: begin
                ram_we   = 1'b1;
                ram_addr = base_reg + addr_t'(1);
            end
            BS_WR2: begin
                ram_we   = 1'b1;
                ram_addr = base_reg + addr_t'(2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BS_IDLE;
            base_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                BS_IDLE: begin
                    if (gray_done) begin
                        state_reg <= BS_RD;
                        base_reg  <= addr_t'(HDR_SIZE + 1);
                    end
                end
                BS_RD:  state_reg <= BS_WR0;
                BS_WR0: state_reg <= BS_WR1;
                BS_WR1: state_reg <= BS_WR2;
                BS_WR2: begin
                    if (base_reg == addr_t'(TOTAL_SIZE - 2)) begin
                        state_reg <= BS_FIN;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= BS_RD;
                        base_reg  <= base_reg + addr_t'(3);
                    end
                end
                BS_FIN: done_reg <= 1'b1;
                default: state_reg <= BS_IDLE;
            endcase
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/bmp_dp_ram.sv
// Dual-port image RAM: port 1 write-only, port 2 read/write with a registered
// read (old data on same-address collision). Port 2 wins a write collision.
module bmp_dp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 104
) (
    input  logic              clk,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we2,
    input  logic              re2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] ram_data [0:DEPTH-1];
    logic [DATA_W-1:0] rdata2_reg;

    // Contents are deliberately never reset; the later port-2 assignment
    // overrides port 1 when both target the same word.
    always_ff @(posedge clk) begin
        if (we1) begin
            ram_data[addr1] <= wdata1;
        end
        if (we2) begin
            ram_data[addr2] <= wdata2;
        end
        if (re2) begin
            rdata2_reg <= ram_data[addr2];
        end
    end

    assign rdata2 = rdata2_reg;

endmodule

// File: rtl/bgr2gray_binarization.sv
// Top: ROM-fed grayscale stage and in-place binarize stage sharing one
// dual-port image RAM; file byte n lives at RAM index n+1.
module bgr2gray_binarization
    import bgr2gray_binarization_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  ROM_ren,
    output logic [ADDR_WIDTH-1:0] ROM_addr,
    input  logic [BYTE_WIDTH-1:0] ROM_out,
    output logic                  gray_done,
    output logic                  done
);

    logic  p1_we;
    addr_t p1_addr;
    byte_t p1_wdata;
    logic  p2_we;
    logic  p2_re;
    addr_t p2_addr;
    byte_t p2_wdata;
    byte_t p2_rdata;

    bgr2gray_stage u_gray (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .rom_ren   (ROM_ren),
        .rom_addr  (ROM_addr),
        .rom_out   (ROM_out),
        .ram_we    (p1_we),
        .ram_addr  (p1_addr),
        .ram_wdata (p1_wdata),
        .gray_done (gray_done)
    );

    binarize_stage u_bin (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_done (gray_done),
        .ram_we    (p2_we),
        .ram_re    (p2_re),
        .ram_addr  (p2_addr),
        .ram_wdata (p2_wdata),
        .ram_rdata (p2_rdata),
        .done      (done)
    );

    bmp_dp_ram #(
        .DATA_W (BYTE_WIDTH),
        .ADDR_W (ADDR_WIDTH),
        .DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .we1    (p1_we),
        .addr1  (p1_addr),
        .wdata1 (p1_wdata),
        .we2    (p2_we),
        .re2    (p2_re),
        .addr2  (p2_addr),
        .wdata2 (p2_wdata),
        .rdata2 (p2_rdata)
    );

endmodule

// File: tb/tb_bgr2gray_binarization.sv
// Directed bench: 4x4 BMP in a ROM model, checks header copy, gray values,
// binarized image, latency and reset behaviour.
module tb_bgr2gray_binarization;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       ROM_ren;
    logic [6:0] ROM_addr;
    logic [7:0] ROM_out;
    logic       gray_done;
    logic       done;

    int checks;
    int failures;

    logic [7:0]  rom      [0:101];
    logic [23:0] pix_bgr  [0:15];
    logic [7:0]  exp_gray [0:15];
    logic [7:0]  exp_bin  [0:15];

    bgr2gray_binarization dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ROM_ren   (ROM_ren),
        .ROM_addr  (ROM_addr),
        .ROM_out   (ROM_out),
        .gray_done (gray_done),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ROM_ren && (ROM_addr < 7'd102)) begin
            ROM_out <= rom[ROM_addr];
        end
    end

    task automatic load_image();
        // pixel bytes are {B, G, R}
        pix_bgr  = '{24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'h808080,
                     24'h7F7F7F, 24'h000000, 24'hFF0000, 24'h102030,
                     24'h40C0A0, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
                     24'h010203, 24'h909090, 24'h817F80, 24'h7F8180};
        exp_gray = '{8'd255, 8'd76,  8'd149, 8'd128,
                     8'd127, 8'd0,   8'd28,  8'd35,
                     8'd167, 8'd178, 8'd226, 8'd105,
                     8'd2,   8'd144, 8'd127, 8'd128};
        exp_bin  = '{8'hFF, 8'h00, 8'hFF, 8'hFF,
                     8'h00, 8'h00, 8'h00, 8'h00,
                     8'hFF, 8'hFF, 8'hFF, 8'h00,
                     8'h00, 8'hFF, 8'h00, 8'hFF};
        rom[0] = 8'h42;
        rom[1] = 8'h4D;
        for (int i = 2; i < 54; i++) rom[i] = 8'(i * 5 + 1);
        for (int p = 0; p < 16; p++) begin
            rom[54 + 3*p]     = pix_bgr[p][23:16];
            rom[54 + 3*p + 1] = pix_bgr[p][15:8];
            rom[54 + 3*p + 2] = pix_bgr[p][7:0];
        end
    endtask

    // Starts one image (in_valid held high throughout), checks gray values at
    // gray_done, then latency, ROM read count, header and binarized image.
    task automatic run_image(input string tag);
        int cyc, gd_cyc, dn_cyc, ren_cnt, idx;
        logic [7:0] got;
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0; gd_cyc = -1; dn_cyc = -1;
        ren_cnt = ROM_ren ? 1 : 0;
        while (dn_cyc < 0 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ROM_ren) ren_cnt++;
            if (gray_done && gd_cyc < 0) begin
                gd_cyc = cyc;
                for (int p = 0; p < 16; p++) begin
                    for (int k = 0; k < 3; k++) begin
                        idx = 55 + 3*p + k;
                        got = dut.u_ram.ram_data[idx];
                        checks++;
                        if (got !== exp_gray[p]) begin
                            failures++;
                            $display("FAIL %s gray pix%0d slot%0d: got %0d expected %0d", tag, p, k, got, exp_gray[p]);
                        end
                    end
                end
            end
            if (done) dn_cyc = cyc;
        end
        in_valid = 1'b0;
        $display("run %s: gray_done at cycle %0d, done at cycle %0d, rom reads %0d", tag, gd_cyc, dn_cyc, ren_cnt);
        checks++;
        if (gd_cyc !== 151) begin
            failures++;
            $display("FAIL %s gray_done latency: got %0d expected 151", tag, gd_cyc);
        end
        checks++;
        if (dn_cyc !== 216) begin
            failures++;
            $display("FAIL %s done latency: got %0d expected 216", tag, dn_cyc);
        end
        checks++;
        if (ren_cnt !== 102) begin
            failures++;
            $display("FAIL %s ROM_ren cycles: got %0d expected 102", tag, ren_cnt);
        end
        for (int i = 0; i < 54; i++) begin
            got = dut.u_ram.ram_data[i + 1];
            checks++;
            if (got !== rom[i]) begin
                failures++;
                $display("FAIL %s header byte%0d: got %h expected %h", tag, i, got, rom[i]);
            end
        end
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 3; k++) begin
                idx = 55 + 3*p + k;
                got = dut.u_ram.ram_data[idx];
                checks++;
                if (got !== exp_bin[p]) begin
                    failures++;
                    $display("FAIL %s bin pix%0d slot%0d: got %h expected %h", tag, p, k, got, exp_bin[p]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ROM_ren !== 1'b0) begin failures++; $display("FAIL reset ROM_ren: got %b expected 0", ROM_ren); end
        checks++;
        if (ROM_addr !== 7'd0) begin failures++; $display("FAIL reset ROM_addr: got %0d expected 0", ROM_addr); end
        checks++;
        if (gray_done !== 1'b0) begin failures++; $display("FAIL reset gray_done: got %b expected 0", gray_done); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b expected 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_idle();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (ROM_ren !== 1'b0) begin failures++; $display("FAIL idle ROM_ren: got %b expected 0", ROM_ren); end
        checks++;
        if (gray_done !== 1'b0) begin failures++; $display("FAIL idle gray_done: got %b expected 0", gray_done); end
        $display("idle: no start without in_valid");
    endtask

    task automatic test_full_run();
        run_image("first");
    endtask

    task automatic test_reset_after_done();
        logic [7:0] got;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gray_done !== 1'b0) begin failures++; $display("FAIL rst_after_done gray_done: got %b expected 0", gray_done); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL rst_after_done done: got %b expected 0", done); end
        got = dut.u_ram.ram_data[55];
        checks++;
        if (got !== 8'hFF) begin failures++; $display("FAIL rst_after_done ram kept pix0: got %h expected ff", got); end
        got = dut.u_ram.ram_data[1];
        checks++;
        if (got !== 8'h42) begin failures++; $display("FAIL rst_after_done ram kept hdr0: got %h expected 42", got); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset after done: flags cleared, RAM kept");
    endtask

    task automatic test_reset_mid_pixel();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        repeat (80) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (ROM_ren !== 1'b1) begin failures++; $display("FAIL mid ROM_ren before reset: got %b expected 1", ROM_ren); end
        checks++;
        if (ROM_addr !== 7'd67) begin failures++; $display("FAIL mid ROM_addr before reset: got %0d expected 67", ROM_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ROM_ren !== 1'b0) begin failures++; $display("FAIL mid reset ROM_ren: got %b expected 0", ROM_ren); end
        checks++;
        if (ROM_addr !== 7'd0) begin failures++; $display("FAIL mid reset ROM_addr: got %0d expected 0", ROM_addr); end
        checks++;
        if (gray_done !== 1'b0) begin failures++; $display("FAIL mid reset gray_done: got %b expected 0", gray_done); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL mid reset done: got %b expected 0", done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid pixel: outputs cleared, restarting");
        run_image("rerun");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ROM_out  = 8'h00;
        load_image();
        test_reset();
        test_idle();
        test_full_run();
        test_reset_after_done();
        test_reset_mid_pixel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
